// File: rtl/cordic_pkg.sv
// Purpose: shared field layout of the 48-bit CORDIC coefficient/result word and the 10-bit tag.
// Latency: n/a (constants, types and pure functions only).
// Backpressure: n/a.
package cordic_pkg;

  // Word layout: {XM[15:0], XR8[7:0], YM[15:0], YR8[7:0]}
  localparam int WORD_W = 48;
  localparam int MAIN_W = 16;
  localparam int RES_W  = 8;
  localparam int XM_MSB = 47;
  localparam int XR_LSB = 24;
  localparam int YM_LSB = 8;

  // Tag layout: {index_qua, index_cor}
  localparam int QUA_W = 3;
  localparam int COR_W = 7;
  localparam int TAG_W = QUA_W + COR_W;

  typedef logic [WORD_W-1:0] cordic_word_t;

  typedef struct packed {
    logic [TAG_W-1:0] addr;
    cordic_word_t     data;
  } result_entry_t;

  // A residual fits in the stored field only if its upper byte is clear.
  function automatic logic residual_clamped(input logic [MAIN_W-1:0] r);
    return (r[MAIN_W-1:RES_W] != '0);
  endfunction

  // Residuals that do not fit saturate to all-ones.
  function automatic logic [RES_W-1:0] sat_residual(input logic [MAIN_W-1:0] r);
    return residual_clamped(r) ? {RES_W{1'b1}} : r[RES_W-1:0];
  endfunction

  // Inverse of the read-side splitter.
  function automatic cordic_word_t pack_word(input logic [MAIN_W-1:0] xm,
                                             input logic [RES_W-1:0]  xr8,
                                             input logic [MAIN_W-1:0] ym,
                                             input logic [RES_W-1:0]  yr8);
    cordic_word_t w;
    w = '0;
    w[XM_MSB -: MAIN_W] = xm;
    w[XR_LSB +: RES_W]  = xr8;
    w[YM_LSB +: MAIN_W] = ym;
    w[RES_W-1:0]        = yr8;
    return w;
  endfunction

endpackage

// File: rtl/result_fifo.sv
// Purpose: small synchronous FIFO, head entry always visible on rdata_o.
// Latency: a push is visible at the head the cycle after the edge that writes it.
// Backpressure: push ignored when full unless a pop happens the same cycle; pop ignored when empty.
module result_fifo #(
  parameter int WIDTH = 58,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // One extra pointer bit separates full from empty when the indices match.
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

  // Pointer advance; wrap modulo DEPTH falls out of the power-of-2 width.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  // Pointer registers; reset empties the FIFO.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage; contents need no reset because empty masks them.
  always_ff @(posedge clk) begin
    if (!reset && do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/cordic_result_writer.sv
// Purpose: repack CORDIC results into 48-bit words and queue them as tagged RAM writes.
// Latency: 1 cycle from wen_in to ram_wen with the FIFO empty; no input-to-output comb path.
// Backpressure: ram_ready stalls the FIFO head; samples arriving full with no pop are dropped (overflow).
module cordic_result_writer
  import cordic_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int NUM_WORDS = 1024
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wen_in,
  input  logic [TAG_W-1:0]    index_cor_in,
  input  logic [MAIN_W-1:0]   XM_in,
  input  logic [MAIN_W-1:0]   YM_in,
  input  logic [MAIN_W-1:0]   XR_in,
  input  logic [MAIN_W-1:0]   YR_in,
  input  logic                ram_ready,
  output logic                ram_wen,
  output logic [TAG_W-1:0]    ram_addr,
  output logic [WORD_W-1:0]   ram_D,
  output logic                full,
  output logic                overflow,
  output logic                sat,
  output logic                done,
  output logic [10:0]         count
);

  localparam logic [10:0] LAST_CNT = 11'(NUM_WORDS - 1);

  result_entry_t wr_entry, rd_entry;
  logic          fifo_empty, fifo_full;
  logic          push, pop, clamp;

  logic [10:0]   count_q, count_d;
  logic          done_q, done_d;
  logic          overflow_q, overflow_d;
  logic          sat_q, sat_d;

  assign clamp         = residual_clamped(XR_in) | residual_clamped(YR_in);
  assign wr_entry.addr = index_cor_in;
  assign wr_entry.data = pack_word(XM_in, sat_residual(XR_in), YM_in, sat_residual(YR_in));

  assign ram_wen = ~fifo_empty;
  assign pop     = ram_wen & ram_ready;
  assign push    = wen_in & (~fifo_full | pop);

  result_fifo #(
    .WIDTH($bits(result_entry_t)),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .push_i (push),
    .pop_i  (pop),
    .wdata_i(wr_entry),
    .rdata_o(rd_entry),
    .full_o (fifo_full),
    .empty_o(fifo_empty)
  );

  // Head is masked to zero while nothing is queued so stale storage never leaks out.
  assign ram_addr = ram_wen ? rd_entry.addr : '0;
  assign ram_D    = ram_wen ? rd_entry.data : '0;
  assign full     = fifo_full;
  assign overflow = overflow_q;
  assign sat      = sat_q;
  assign done     = done_q;
  assign count    = count_q;

  // Frame counter wraps on the last pop of a frame; sticky flags only ever set.
  always_comb begin
    count_d    = count_q;
    done_d     = 1'b0;
    overflow_d = overflow_q | (wen_in & fifo_full & ~pop);
    sat_d      = sat_q | (wen_in & clamp);
    if (pop) begin
      if (count_q == LAST_CNT) begin
        count_d = '0;
        done_d  = 1'b1;
      end else begin
        count_d = count_q + 11'd1;
      end
    end
  end

  // Status registers; reset wins over any activity in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q    <= '0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
      sat_q      <= 1'b0;
    end else begin
      count_q    <= count_d;
      done_q     <= done_d;
      overflow_q <= overflow_d;
      sat_q      <= sat_d;
    end
  end

endmodule

// File: doc/cordic_result_writer.md
# cordic_result_writer

Write-side counterpart of the CORDIC ROM-read front end. Accepts the per-sample outputs of the CORDIC pipeline (main/residual X and Y words plus the 10-bit quadrant/index tag) and repacks them into the 48-bit word format used by the coefficient/result memories. A small FIFO absorbs memory-port stalls, and the tag becomes the write address. The block sits at the tail of the CORDIC pipeline, after the final `buffer_cordic_cell` stage, and drives a single-port result RAM.

## Interface
- `DEPTH`, default 4: FIFO entries, a power of 2 and at least 2.
- `NUM_WORDS`, default 1024: accepted writes per frame; `done` pulses when this count is reached.
- `clk`, in, 1: single clock, rising edge.
- `reset`, in, 1: synchronous, active-high.
- `wen_in`, in, 1: result valid this cycle.
- `index_cor_in`, in, 10: `{index_qua[2:0], index_cor[6:0]}`.
- `XM_in`, `YM_in`, in, 16: main X/Y results.
- `XR_in`, `YR_in`, in, 16: residual X/Y results; only `[7:0]` is stored.
- `ram_ready`, in, 1: RAM accepts a write this cycle.
- `ram_wen`, out, 1: write request, which is also the FIFO non-empty flag.
- `ram_addr`, out, 10: write address, taken from the tag.
- `ram_D`, out, 48: packed word.
- `full`, out, 1: FIFO holds `DEPTH` entries.
- `overflow`, out, 1: sticky; a sample was dropped.
- `sat`, out, 1: sticky; a residual was clamped.
- `done`, out, 1: one-cycle frame-complete pulse.
- `count`, out, 11: writes accepted in the current frame.

## Operation
- Packing, the inverse of the ROM split:
  - `ram_D[47:32] = XM`
  - `ram_D[31:24] = XR8`
  - `ram_D[23:8] = YM`
  - `ram_D[7:0] = YR8`
- Residual rule:
  - `XR8 = (XR_in[15:8] == 0) ? XR_in[7:0] : 8'hFF`; `YR8` follows the same rule.
  - Any clamp sets `sat`.
  - The stored address is `index_cor_in` unchanged.
- Push: when `wen_in` is high and (not `full` or a pop occurs the same cycle), the entry is written at the tail.
- Drop: when `wen_in`, `full` and no pop are all true, the sample is discarded and `overflow` is set. FIFO contents are unchanged.
- Pop: fires when `ram_wen & ram_ready` is true; the head advances.
  - `ram_addr` and `ram_D` always show the head entry.
  - They are don't-care while `ram_wen` is 0; the implementation drives 0.
- Pointers: both wrap modulo `DEPTH`. Occupancy runs 0..`DEPTH`, tracked with one extra pointer bit.
- Frame counter:
  - `count` increments on every pop.
  - On the pop that makes it `NUM_WORDS`, `count` returns to 0 and `done` pulses in the following cycle.
  - `overflow` and `sat` are not cleared by `done`.
- Reset, synchronous, priority over everything:
  - FIFO empties.
  - All outputs go to 0: `ram_wen`, `ram_addr`, `ram_D`, `full`, `overflow`, `sat`, `done`, `count`.
  - A write pending when reset arrives is lost. A `wen_in` in the reset cycle is ignored.

## Timing
- Latency: with the FIFO empty, a `wen_in` at edge N gives `ram_wen = 1` with that word's data after edge N. This is one cycle, with no combinational path from inputs to `ram_*`.
- Throughput: one word per cycle while `ram_ready` is held high.
- `full` is registered. It reflects occupancy after the last edge.
- Simultaneous push and pop when full: both occur and occupancy stays at `DEPTH`.
- Simultaneous push and pop when empty: not possible; the push lands and the pop cannot happen because `ram_wen` was 0.
- `ram_ready` may toggle at any time. Head data is held stable while `ram_wen = 1` and `ram_ready = 0`.
- `done` is registered and lasts exactly one cycle.

## Structure
- Shared package `cordic_pkg`:
  - Field offsets/widths: `XM_MSB = 47`, `XR_LSB = 24`, `YM_LSB = 8`, residual width 8.
  - Tag layout: `QUA_W = 3`, `COR_W = 7`.
  - The 48-bit word typedef.
  - The same constants serve the read-side splitter.
- One sub-module, `result_fifo` (parameterised width and depth, synchronous reset, push/pop/full/empty), holding 58-bit entries (10-bit address + 48-bit data).
- Packing, saturation and the frame counter live in the top level.

## Test plan
- Single word: reset, then `wen_in` with `XM = 16'h1234`, `XR = 16'h0056`, `YM = 16'h789A`, `YR = 16'h00BC`, `tag = 10'h2A5`, `ram_ready = 1`. Next cycle `ram_wen = 1`, `ram_addr = 10'h2A5`, `ram_D = 48'h1234_56_789A_BC`; `count = 1` after the pop.
- Saturation: `XR_in = 16'h0100`, `YR_in = 16'h0003`. Then `ram_D[31:24] = 8'hFF`, `ram_D[7:0] = 8'h03`, and `sat` goes high and stays high.
- Stall and overflow: `ram_ready = 0`, push 5 words (tags 0..4) with `DEPTH = 4`. `full` is high after the 4th push, the 5th word is dropped and `overflow = 1`. Releasing `ram_ready` drains addresses 0,1,2,3 in order, and `ram_wen` falls after the 4th pop.
- Full with simultaneous push/pop: fill to 4, then drive `wen_in` and `ram_ready` together for 6 cycles. No drop occurs, `overflow` stays 0, and output order matches input order.
- Frame done: `NUM_WORDS = 8`, stream 8 words with `ram_ready = 1`. `done` pulses once the cycle after the 8th pop, `count` reads 0 and then resumes at 1 on the next write.
- Reset mid-operation: with 3 queued entries and `overflow = 1`, assert `reset` for one cycle. All outputs are 0 the next cycle, and the first subsequent word appears alone with `count = 1`.
